// File: rtl/ws2812b_frame_sampler_if.sv
// Bus between the frame sampler and its neighbours: raw LED requests in, committed frame out.
interface ws2812b_frame_sampler_if #(
  parameter int N = 32
);
  logic         enable;
  logic [N-1:0] raw_in;
  logic [N-1:0] frame_out;
  logic         frame_strobe;
  logic         busy;
  logic         pending;
  logic [1:0]   state_dbg;

  // Valid-only handshake: frame_strobe is the valid flag for frame_out, high for exactly one
  // cycle per commit; there is no ready because the consumer must accept every frame.
  modport master (
    output enable, raw_in,
    input  frame_out, frame_strobe, busy, pending, state_dbg
  );

  modport slave (
    input  enable, raw_in,
    output frame_out, frame_strobe, busy, pending, state_dbg
  );
endinterface

// File: rtl/ws2812b_frame_sampler.sv
// Synchronises raw LED requests, rate-limits and debounces them, then holds each committed
// frame long enough for the strip controller to finish a full refresh.
module ws2812b_frame_sampler #(
  parameter int N             = 32,
  parameter int CLK_HZ        = 50_000_000,
  parameter int SAMPLE_HZ     = 1000,
  parameter int STABLE_CYCLES = 500,
  parameter int HOLD_CYCLES   = 50_000
) (
  input logic                   clk_50,
  input logic                   rst,
  ws2812b_frame_sampler_if.slave bus
);

  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int PRE_W      = $clog2(SAMPLE_DIV);
  localparam int STAB_W     = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W     = $clog2(HOLD_CYCLES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  generate
    if (SAMPLE_DIV < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
      $error("ws2812b_frame_sampler: SAMPLE_DIV must be >= 2, STABLE/HOLD_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [N-1:0]       sync_a, sync_q;
  logic [PRE_W-1:0]   presc;
  logic               tick;
  logic [N-1:0]       cand, cand_nx;
  logic [STAB_W-1:0]  stab_cnt, stab_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [N-1:0]       frame_r, frame_nx;
  logic               strobe_r, strobe_nx;
  logic               busy_r, busy_nx;
  logic               pending_r, pending_nx;

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_q <= '0;
    end else begin
      sync_a <= bus.raw_in;
      sync_q <= sync_a;
    end
  end

  // Prescaler parks at zero while disabled so re-enabling restarts a full sample period.
  assign tick = bus.enable && (presc == PRE_LAST);

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (!bus.enable || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (tick && (sync_q != frame_r)) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        // Disable wins over a completing candidate; a bounce back to the shown frame aborts.
        if (!bus.enable) begin
          state_nx = S_IDLE;
        end else if (sync_q != cand) begin
          if (sync_q == frame_r) state_nx = S_IDLE;
        end else if (stab_cnt == STAB_LAST) begin
          state_nx = S_COMMIT;
        end
      end
      S_COMMIT: state_nx = S_HOLD;
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cand_nx    = cand;
    stab_nx    = stab_cnt;
    hold_nx    = hold_cnt;
    frame_nx   = frame_r;
    case (state)
      S_IDLE: begin
        if (tick && (sync_q != frame_r)) begin
          cand_nx = sync_q;
          stab_nx = '0;
        end
      end
      S_SETTLE: begin
        if (sync_q != cand) begin
          cand_nx = sync_q;
          stab_nx = '0;
        end else if (stab_cnt != STAB_LAST) begin
          stab_nx = stab_cnt + 1'b1;
        end
      end
      S_COMMIT: begin
        frame_nx = cand;
        hold_nx  = '0;
      end
      S_HOLD: begin
        if (hold_cnt != HOLD_LAST) hold_nx = hold_cnt + 1'b1;
      end
      default: ;
    endcase
    strobe_nx  = (state == S_COMMIT);
    busy_nx    = (state_nx != S_IDLE);
    pending_nx = (sync_q != frame_r);
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      cand      <= '0;
      stab_cnt  <= '0;
      hold_cnt  <= '0;
      frame_r   <= '0;
      strobe_r  <= 1'b0;
      busy_r    <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      cand      <= cand_nx;
      stab_cnt  <= stab_nx;
      hold_cnt  <= hold_nx;
      frame_r   <= frame_nx;
      strobe_r  <= strobe_nx;
      busy_r    <= busy_nx;
      pending_r <= pending_nx;
    end
  end

  assign bus.frame_out    = frame_r;
  assign bus.frame_strobe = strobe_r;
  assign bus.busy         = busy_r;
  assign bus.pending      = pending_r;
  assign bus.state_dbg    = state;

endmodule
